if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC, drives the instruction-memory address, and selects the next PC: sequential, taken branch or jump, all resolved in ID.
- Latches the fetched instruction and PC+4 into IF/ID.
- Directly consumes the hazard unit's PCWrite and IF_ID_Write stall controls; flushes IF/ID on redirect; keeps saturating stall/flush event counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction (sll $0,$0,0) inserted into IF/ID on flush or reset.
- CNT_WIDTH, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- PCWrite  in  1  from hazard unit; 0 holds the PC.
- IF_ID_Write  in  1  from hazard unit; 0 holds the IF/ID register.
- branch_taken  in  1  ID-stage branch resolved taken.
- branch_offset  in  16  ID-stage immediate (word offset, signed).
- jump  in  1  ID-stage J/JAL.
- jump_index  in  26  ID-stage jump target field.
- imem_addr  out  32  current PC to instruction memory (combinational read).
- imem_data  in  32  instruction at imem_addr, same cycle.
- IF_ID_Instr  out  32  registered instruction.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  0 when IF/ID holds an inserted bubble.
- stall_count  out  CNT_WIDTH  cycles with PCWrite=0, saturating.
- flush_count  out  CNT_WIDTH  redirects applied, saturating.

Behaviour:
- Reset (rst=1 at posedge) overrides all inputs:
  - PC=RESET_PC; IF_ID_Instr=NOP_INSTR; IF_ID_PCPlus4=0; IF_ID_Valid=0.
  - Both counters=0.
  - Reset asserted mid-stall or mid-redirect discards that event.
- imem_addr = PC, combinational from the PC register. pc_plus4 = PC + 32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Redirect targets:
  - Branch target = IF_ID_PCPlus4 + (sign_extend(branch_offset) << 2), modulo 2^32.
  - Jump target = {IF_ID_PCPlus4[31:28], jump_index, 2'b00}.
  - jump has priority over branch_taken when both are asserted.
- redirect = (jump | branch_taken) & IF_ID_Valid. Redirect requests from a bubble are ignored.
- PC update priority per posedge:
  1. rst.
  2. PCWrite=0: PC holds; any redirect is ignored this cycle (the stalled ID instruction re-resolves next cycle).
  3. redirect: PC = target.
  4. Otherwise PC = pc_plus4.
- IF/ID update priority per posedge:
  1. rst.
  2. IF_ID_Write=0: hold all three fields.
  3. redirect with PCWrite=1: flush. Instr=NOP_INSTR, PCPlus4 unchanged, Valid=0. This gives a one-cycle branch penalty, no delay slot.
  4. Otherwise Instr=imem_data, PCPlus4=pc_plus4, Valid=1.
- PCWrite and IF_ID_Write are handled independently. The normal hazard unit drives them equal; mismatched combinations follow the rules above and must not corrupt state.
- stall_count increments on every non-reset cycle with PCWrite=0. flush_count increments on every applied flush. Both saturate at all-ones and never wrap.
- Latency:
  - Fetched instruction appears on IF_ID_Instr one cycle after its PC is on imem_addr.
  - A redirect request is visible on imem_addr the following cycle.
- No X propagation: all registers are reset; imem_data is sampled only on the normal-advance path.

Decomposition:
- Shared pipeline package (cpu_pkg):
  - NOP_INSTR.
  - RESET_PC.
  - Instruction width 32.
  - Opcode-independent constants shared with the hazard unit and ID stage.
- One natural sub-module: if_id_reg. Holds Instr/PCPlus4/Valid with write-enable and flush inputs and is reusable for the other pipeline registers.
- The PC/next-PC mux and the counters stay in the top.

Test Plan:
- Reset then 4 free-run cycles, imem returning 0x8C010000+PC → imem_addr sequence 0,4,8,C. IF_ID_Valid=0 in the first cycle, then 1. IF_ID_PCPlus4 = 4, 8, C on successive cycles.
- PCWrite=IF_ID_Write=0 for 3 cycles at PC=0x10 → imem_addr stays 0x10; IF/ID unchanged; stall_count=3. On release, imem_addr goes to 0x14.
- branch_taken=1, offset=16'hFFFE, IF_ID_PCPlus4=0x20 → next imem_addr=0x18; IF_ID_Instr=NOP_INSTR, Valid=0; flush_count+1. Next cycle branch_taken=1 is ignored (Valid=0).
- jump=1 and branch_taken=1 together, jump_index=26'h0000040, IF_ID_PCPlus4=0x1000_0004 → imem_addr=0x1000_0100.
- redirect asserted while PCWrite=0 → PC holds, no flush, flush_count unchanged. PC=0xFFFFFFFC free-running → next PC=0x0. Force 2^CNT_WIDTH+5 stall cycles → stall_count holds at 0xFFFF.
- rst asserted mid-stall at PC=0x40 → next cycle PC=RESET_PC, Valid=0, counters=0, regardless of PCWrite/redirect.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline constants and helpers for the fetch stage and its neighbours.
// The IF/ID payload struct is reused by the other pipeline registers.
package if_fetch_stage_pkg;

    localparam int unsigned INSTR_W           = 32;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc_plus4;
        logic               valid;
    } if_id_t;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] offset);
        return pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

    // Region is the upper nibble of the delay-slot-free PC+4.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, ID redirect, instruction memory and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_fetch_stage_if
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) ();

    logic                 PCWrite;
    logic                 IF_ID_Write;
    logic                 branch_taken;
    logic [15:0]          branch_offset;
    logic                 jump;
    logic [25:0]          jump_index;
    logic [31:0]          imem_addr;
    logic [INSTR_W-1:0]   imem_data;
    logic [INSTR_W-1:0]   IF_ID_Instr;
    logic [31:0]          IF_ID_PCPlus4;
    logic                 IF_ID_Valid;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        input  PCWrite, IF_ID_Write, branch_taken, branch_offset, jump, jump_index, imem_data,
        output imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, stall_count, flush_count
    );

    modport slave (
        output PCWrite, IF_ID_Write, branch_taken, branch_offset, jump, jump_index, imem_data,
        input  imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, stall_count, flush_count
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// Pipeline register holding instruction, PC+4 and valid, with write-enable and flush.
// A flush keeps PC+4 so only instr/valid change when a bubble is inserted.
module if_fetch_stage_if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   we_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t if_id_q, if_id_d;

    // Write-enable outranks flush; d_i is only sampled on a plain advance.
    always_comb begin
        if_id_d = if_id_q;
        if (we_i) begin
            if (flush_i) begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
            end else begin
                if_id_d = d_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc_plus4 <= '0;
            if_id_q.valid    <= 1'b0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign q_o = if_id_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection from ID redirects,
// IF/ID register and saturating stall/flush event counters.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0]        RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int unsigned        CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_stage_if.master  bus
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pc_plus4;
    logic [31:0]          redirect_target;
    logic                 redirect;
    logic                 flush;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
    if_id_t               if_id_in, if_id_out;

    assign pc_plus4 = pc_q + PC_STEP;

    // A bubble in ID carries no real branch/jump, so its request is dropped.
    assign redirect = (bus.jump | bus.branch_taken) & if_id_out.valid;
    assign redirect_target = bus.jump
        ? jump_target(if_id_out.pc_plus4[31:28], bus.jump_index)
        : branch_target(if_id_out.pc_plus4, bus.branch_offset);
    assign flush = redirect & bus.PCWrite;

    always_comb begin
        pc_d = pc_q;
        if (bus.PCWrite) begin
            pc_d = redirect ? redirect_target : pc_plus4;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!bus.PCWrite && stall_count_q != CntMax) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
        // Only count flushes the IF/ID register actually applied.
        if (flush && bus.IF_ID_Write && flush_count_q != CntMax) begin
            flush_count_d = flush_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        if_id_in.instr    = bus.imem_data;
        if_id_in.pc_plus4 = pc_plus4;
        if_id_in.valid    = 1'b1;
    end

    if_fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bus.IF_ID_Write),
        .flush_i (flush),
        .d_i     (if_id_in),
        .q_o     (if_id_out)
    );

    assign bus.imem_addr     = pc_q;
    assign bus.IF_ID_Instr   = if_id_out.instr;
    assign bus.IF_ID_PCPlus4 = if_id_out.pc_plus4;
    assign bus.IF_ID_Valid   = if_id_out.valid;
    assign bus.stall_count   = stall_count_q;
    assign bus.flush_count   = flush_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic against a
// cycle-level reference model of the fetch rules.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] IMEM = 32'h8C01_0000;
    localparam logic [15:0] SAT  = 16'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_hi = 1'b1;
    int   tests_run = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    if_fetch_stage_if #(.CNT_WIDTH(16)) bus ();
    if_fetch_stage_if #(.CNT_WIDTH(16)) bus_hi ();

    assign bus.imem_data    = IMEM + bus.imem_addr;
    assign bus_hi.imem_data = IMEM + bus_hi.imem_addr;

    // Second instance shares all stimulus but resets into the 0x1xxx_xxxx region.
    assign bus_hi.PCWrite       = bus.PCWrite;
    assign bus_hi.IF_ID_Write   = bus.IF_ID_Write;
    assign bus_hi.branch_taken  = bus.branch_taken;
    assign bus_hi.branch_offset = bus.branch_offset;
    assign bus_hi.jump          = bus.jump;
    assign bus_hi.jump_index    = bus.jump_index;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .CNT_WIDTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_fetch_stage #(
        .RESET_PC  (32'h1000_0000),
        .NOP_INSTR (NOP),
        .CNT_WIDTH (16)
    ) dut_hi (
        .clk (clk),
        .rst (rst_hi),
        .bus (bus_hi)
    );

    // Reference model state for the main instance.
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid;
    logic [15:0] m_stall, m_flush;

    task automatic set_in(input logic pw, input logic iw, input logic bt,
                          input logic [15:0] off, input logic j, input logic [25:0] idx);
        bus.PCWrite       = pw;
        bus.IF_ID_Write   = iw;
        bus.branch_taken  = bt;
        bus.branch_offset = off;
        bus.jump          = j;
        bus.jump_index    = idx;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic        redir;
        logic [31:0] tgt;
        redir = (bus.jump || bus.branch_taken) && m_valid;
        if (bus.jump) tgt = (m_pcp4 & 32'hF000_0000) | (32'(bus.jump_index) * 32'd4);
        else          tgt = m_pcp4 + 32'(int'($signed(bus.branch_offset)) * 4);
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0;
            m_stall = 16'h0; m_flush = 16'h0;
        end else begin
            if (!bus.PCWrite && m_stall != SAT) m_stall = m_stall + 16'd1;
            if (bus.IF_ID_Write) begin
                if (redir && bus.PCWrite) begin
                    m_instr = NOP; m_valid = 1'b0;
                    if (m_flush != SAT) m_flush = m_flush + 16'd1;
                end else begin
                    m_instr = IMEM + m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
                end
            end
            if (bus.PCWrite) m_pc = redir ? tgt : m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
        rst = 1'b0;
        tests_run += 6;
        if (bus.imem_addr !== 32'h0) begin
            failures++; $display("FAIL reset_pc: got %h want %h", bus.imem_addr, 32'h0);
        end
        if (bus.IF_ID_Instr !== NOP) begin
            failures++; $display("FAIL reset_instr: got %h want %h", bus.IF_ID_Instr, NOP);
        end
        if (bus.IF_ID_PCPlus4 !== 32'h0) begin
            failures++; $display("FAIL reset_pcp4: got %h want 0", bus.IF_ID_PCPlus4);
        end
        if (bus.IF_ID_Valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b want 0", bus.IF_ID_Valid);
        end
        if (bus.stall_count !== 16'h0) begin
            failures++; $display("FAIL reset_stall: got %h want 0", bus.stall_count);
        end
        if (bus.flush_count !== 16'h0) begin
            failures++; $display("FAIL reset_flush: got %h want 0", bus.flush_count);
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run += 4;
            if (bus.imem_addr !== 32'(i * 4)) begin
                failures++; $display("FAIL run_addr[%0d]: got %h want %h", i, bus.imem_addr, i * 4);
            end
            if (bus.IF_ID_PCPlus4 !== 32'(i * 4)) begin
                failures++;
                $display("FAIL run_pcp4[%0d]: got %h want %h", i, bus.IF_ID_PCPlus4, i * 4);
            end
            if (bus.IF_ID_Instr !== IMEM + 32'((i - 1) * 4)) begin
                failures++;
                $display("FAIL run_instr[%0d]: got %h want %h", i, bus.IF_ID_Instr,
                         IMEM + 32'((i - 1) * 4));
            end
            if (bus.IF_ID_Valid !== 1'b1) begin
                failures++; $display("FAIL run_valid[%0d]: got %b want 1", i, bus.IF_ID_Valid);
            end
        end
    endtask

    task automatic test_stall();
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        repeat (3) begin
            tick();
            tests_run += 2;
            if (bus.imem_addr !== 32'h10) begin
                failures++; $display("FAIL stall_addr: got %h want %h", bus.imem_addr, 32'h10);
            end
            if (bus.IF_ID_Instr !== IMEM + 32'hC || bus.IF_ID_PCPlus4 !== 32'h10) begin
                failures++;
                $display("FAIL stall_ifid: got %h/%h want %h/%h", bus.IF_ID_Instr,
                         bus.IF_ID_PCPlus4, IMEM + 32'hC, 32'h10);
            end
        end
        tests_run++;
        if (bus.stall_count !== 16'd3) begin
            failures++; $display("FAIL stall_count: got %0d want 3", bus.stall_count);
        end
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
        tests_run++;
        if (bus.imem_addr !== 32'h14) begin
            failures++; $display("FAIL stall_release: got %h want %h", bus.imem_addr, 32'h14);
        end
    endtask

    task automatic test_branch();
        repeat (3) tick();
        tests_run++;
        if (bus.IF_ID_PCPlus4 !== 32'h20) begin
            failures++; $display("FAIL br_setup: got %h want %h", bus.IF_ID_PCPlus4, 32'h20);
        end
        set_in(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 26'h0);
        tick();
        tests_run += 4;
        if (bus.imem_addr !== 32'h18) begin
            failures++; $display("FAIL br_target: got %h want %h", bus.imem_addr, 32'h18);
        end
        if (bus.IF_ID_Instr !== NOP || bus.IF_ID_Valid !== 1'b0) begin
            failures++;
            $display("FAIL br_flush: got %h/%b want %h/0", bus.IF_ID_Instr, bus.IF_ID_Valid, NOP);
        end
        if (bus.IF_ID_PCPlus4 !== 32'h20) begin
            failures++; $display("FAIL br_pcp4_kept: got %h want %h", bus.IF_ID_PCPlus4, 32'h20);
        end
        if (bus.flush_count !== 16'd1) begin
            failures++; $display("FAIL br_flush_count: got %0d want 1", bus.flush_count);
        end
        tick();
        tests_run += 3;
        if (bus.imem_addr !== 32'h1C) begin
            failures++; $display("FAIL br_bubble_ignored: got %h want %h", bus.imem_addr, 32'h1C);
        end
        if (bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_PCPlus4 !== 32'h1C) begin
            failures++;
            $display("FAIL br_refetch: got %b/%h want 1/%h", bus.IF_ID_Valid, bus.IF_ID_PCPlus4,
                     32'h1C);
        end
        if (bus.flush_count !== 16'd1) begin
            failures++; $display("FAIL br_flush_hold: got %0d want 1", bus.flush_count);
        end
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    endtask

    task automatic test_jump_priority();
        rst_hi = 1'b1;
        tick();
        rst_hi = 1'b0;
        tick();
        tests_run++;
        if (bus_hi.IF_ID_PCPlus4 !== 32'h1000_0004) begin
            failures++;
            $display("FAIL jmp_setup: got %h want %h", bus_hi.IF_ID_PCPlus4, 32'h1000_0004);
        end
        set_in(1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, 26'h0000040);
        tick();
        tests_run += 2;
        if (bus_hi.imem_addr !== 32'h1000_0100) begin
            failures++;
            $display("FAIL jmp_target: got %h want %h", bus_hi.imem_addr, 32'h1000_0100);
        end
        if (bus_hi.IF_ID_Valid !== 1'b0) begin
            failures++; $display("FAIL jmp_flush: got %b want 0", bus_hi.IF_ID_Valid);
        end
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
    endtask

    task automatic test_stall_redirect();
        logic [31:0] pc_exp;
        logic [15:0] fl_exp;
        tick();
        pc_exp = m_pc;
        fl_exp = m_flush;
        set_in(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 26'h0);
        tick();
        tests_run += 3;
        if (bus.imem_addr !== pc_exp) begin
            failures++; $display("FAIL stallredir_pc: got %h want %h", bus.imem_addr, pc_exp);
        end
        if (bus.flush_count !== fl_exp) begin
            failures++; $display("FAIL stallredir_flush: got %0d want %0d", bus.flush_count, fl_exp);
        end
        if (bus.IF_ID_Valid !== 1'b1) begin
            failures++; $display("FAIL stallredir_valid: got %b want 1", bus.IF_ID_Valid);
        end
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_in(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 26'h0);
        tick();
        tests_run++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_setup: got %h want %h", bus.imem_addr, 32'hFFFF_FFFC);
        end
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
        tests_run += 2;
        if (bus.imem_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_pc: got %h want 0", bus.imem_addr);
        end
        if (bus.IF_ID_PCPlus4 !== 32'h0 || bus.IF_ID_Instr !== 32'h8C00_FFFC) begin
            failures++;
            $display("FAIL wrap_ifid: got %h/%h want 0/%h", bus.IF_ID_PCPlus4, bus.IF_ID_Instr,
                     32'h8C00_FFFC);
        end
    endtask

    task automatic test_random();
        logic pw;
        for (int i = 0; i < 400; i++) begin
            pw = ($urandom_range(9) != 0);
            set_in(pw, ($urandom_range(6) == 0) ? 1'($urandom) : pw,
                   ($urandom_range(4) == 0), 16'($urandom), ($urandom_range(9) == 0),
                   26'($urandom));
            rst = ($urandom_range(49) == 0);
            tick();
            tests_run += 6;
            if (bus.imem_addr !== m_pc) begin
                failures++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.imem_addr, m_pc);
            end
            if (bus.IF_ID_Instr !== m_instr) begin
                failures++;
                $display("FAIL rnd_instr[%0d]: got %h want %h", i, bus.IF_ID_Instr, m_instr);
            end
            if (bus.IF_ID_PCPlus4 !== m_pcp4) begin
                failures++;
                $display("FAIL rnd_pcp4[%0d]: got %h want %h", i, bus.IF_ID_PCPlus4, m_pcp4);
            end
            if (bus.IF_ID_Valid !== m_valid) begin
                failures++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.IF_ID_Valid, m_valid);
            end
            if (bus.stall_count !== m_stall) begin
                failures++;
                $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, bus.stall_count, m_stall);
            end
            if (bus.flush_count !== m_flush) begin
                failures++;
                $display("FAIL rnd_flush[%0d]: got %0d want %0d", i, bus.flush_count, m_flush);
            end
        end
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        repeat (65536 + 5) tick();
        tests_run += 2;
        if (bus.stall_count !== SAT) begin
            failures++; $display("FAIL sat_stall: got %h want %h", bus.stall_count, SAT);
        end
        if (bus.imem_addr !== 32'h0) begin
            failures++; $display("FAIL sat_pc_hold: got %h want 0", bus.imem_addr);
        end
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    endtask

    task automatic test_reset_mid_stall();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (16) tick();
        tests_run++;
        if (bus.imem_addr !== 32'h40) begin
            failures++; $display("FAIL rms_setup: got %h want %h", bus.imem_addr, 32'h40);
        end
        set_in(1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 26'h0000123);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run += 4;
        if (bus.imem_addr !== 32'h0) begin
            failures++; $display("FAIL rms_pc: got %h want 0", bus.imem_addr);
        end
        if (bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instr !== NOP) begin
            failures++;
            $display("FAIL rms_ifid: got %b/%h want 0/%h", bus.IF_ID_Valid, bus.IF_ID_Instr, NOP);
        end
        if (bus.stall_count !== 16'h0) begin
            failures++; $display("FAIL rms_stall: got %0d want 0", bus.stall_count);
        end
        if (bus.flush_count !== 16'h0) begin
            failures++; $display("FAIL rms_flush: got %0d want 0", bus.flush_count);
        end
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_jump_priority();
        test_stall_redirect();
        test_wrap();
        test_random();
        test_saturate();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
